// File: rtl/fll_lock_seq.sv
// rtl/fll_lock_seq.sv - FLL lock sequencer: reset, acquire, lock monitor, bounded retry
// Optional rail-fault detection in LOCKED is enabled by defining FLL_RAIL_DET_EN.
`timescale 1ns/1ps
module fll_lock_seq #(
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 1023,
    parameter int TMR_W        = 10,
    parameter int LOL_FILTER   = 3,
    parameter int MAX_RETRY    = 3,
    parameter int RAIL_CYCLES  = 8
) (
    input  logic       ref_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [5:0] multi_cfg,
    input  logic [4:0] avg_cfg,
    input  logic       lock_flag,
    input  logic [4:0] clk_con,
    output logic       fll_rst,
    output logic [5:0] multi,
    output logic [4:0] avg_window,
    output logic       busy,
    output logic       locked,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [7:0] lol_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_ACQUIRE,
        S_LOCKED,
        S_FAIL
    } state_t;

    localparam int LOL_W = $clog2(LOL_FILTER + 1);

    state_t             state;
    logic               sync1;
    logic               lock_s;
    logic [TMR_W-1:0]   timer;
    logic [LOL_W-1:0]   lol_streak;
    logic               cfg_ok;
    logic               lol_hit;
    logic               lol_event;
    logic               acq_timeout;
    logic               fault;
    logic               can_retry;

`ifdef FLL_RAIL_DET_EN
    localparam int RAIL_W = $clog2(RAIL_CYCLES + 1);
    logic [RAIL_W-1:0]  rail_streak;
    logic               at_rail;
    logic               rail_hit;

    assign at_rail   = (clk_con == 5'd0) || (clk_con == 5'd31);
    assign rail_hit  = at_rail && (rail_streak == RAIL_W'(RAIL_CYCLES - 1));
    // Filter and rail hitting together still count as a single event.
    assign lol_event = lol_hit || rail_hit;
`else
    logic unused_clk_con;
    assign unused_clk_con = ^clk_con;
    assign lol_event      = lol_hit;
`endif

    assign cfg_ok      = (multi_cfg >= 6'd2);
    assign lol_hit     = !lock_s && (lol_streak == LOL_W'(LOL_FILTER - 1));
    assign acq_timeout = !lock_s && (timer == TMR_W'(LOCK_TIMEOUT - 1));
    assign fault       = ((state == S_ACQUIRE) && acq_timeout) ||
                         ((state == S_LOCKED) && lol_event);
    assign can_retry   = (retry_cnt < 2'(MAX_RETRY));

    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            sync1      <= 1'b0;
            lock_s     <= 1'b0;
            timer      <= '0;
            lol_streak <= '0;
`ifdef FLL_RAIL_DET_EN
            rail_streak <= '0;
`endif
            fll_rst    <= 1'b1;
            multi      <= '0;
            avg_window <= '0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
            retry_cnt  <= '0;
            lol_cnt    <= '0;
        end else begin
            sync1  <= lock_flag;
            lock_s <= sync1;
            if (stop) begin
                state   <= S_IDLE;
                fll_rst <= 1'b1;
                busy    <= 1'b0;
                locked  <= 1'b0;
                fail    <= 1'b0;
            end else if (fault) begin
                if (state == S_LOCKED && lol_cnt != 8'hFF)
                    lol_cnt <= lol_cnt + 8'd1;
                locked  <= 1'b0;
                fll_rst <= 1'b1;
                timer   <= '0;
                if (can_retry) begin
                    retry_cnt <= retry_cnt + 2'd1;
                    state     <= S_RESET;
                    busy      <= 1'b1;
                end else begin
                    state <= S_FAIL;
                    busy  <= 1'b0;
                    fail  <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE, S_FAIL: begin
                        if (start) begin
                            if (cfg_ok) begin
                                multi      <= multi_cfg;
                                avg_window <= avg_cfg;
                                retry_cnt  <= '0;
                                timer      <= '0;
                                state      <= S_RESET;
                                busy       <= 1'b1;
                                fail       <= 1'b0;
                                fll_rst    <= 1'b1;
                            end else begin
                                state <= S_FAIL;
                                fail  <= 1'b1;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    S_RESET: begin
                        if (timer == TMR_W'(RST_CYCLES - 1)) begin
                            state   <= S_ACQUIRE;
                            timer   <= '0;
                            fll_rst <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_ACQUIRE: begin
                        timer <= timer + 1'b1;
                        if (lock_s) begin
                            state      <= S_LOCKED;
                            locked     <= 1'b1;
                            lol_streak <= '0;
`ifdef FLL_RAIL_DET_EN
                            rail_streak <= '0;
`endif
                        end
                    end
                    S_LOCKED: begin
                        lol_streak <= lock_s ? '0 : lol_streak + 1'b1;
`ifdef FLL_RAIL_DET_EN
                        rail_streak <= at_rail ? rail_streak + 1'b1 : '0;
`endif
                    end
                    default: begin
                        state   <= S_IDLE;
                        fll_rst <= 1'b1;
                        busy    <= 1'b0;
                        locked  <= 1'b0;
                        fail    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fll_lock_seq.sv
// tb/tb_fll_lock_seq.sv - self-checking bench for fll_lock_seq
// Rail checks follow FLL_RAIL_DET_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fll_lock_seq;

    logic       ref_clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic [5:0] multi_cfg;
    logic [4:0] avg_cfg;
    logic       lock_flag;
    logic [4:0] clk_con;
    logic       fll_rst;
    logic [5:0] multi;
    logic [4:0] avg_window;
    logic       busy;
    logic       locked;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lol_cnt;

    fll_lock_seq dut (
        .ref_clk    (ref_clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .multi_cfg  (multi_cfg),
        .avg_cfg    (avg_cfg),
        .lock_flag  (lock_flag),
        .clk_con    (clk_con),
        .fll_rst    (fll_rst),
        .multi      (multi),
        .avg_window (avg_window),
        .busy       (busy),
        .locked     (locked),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .lol_cnt    (lol_cnt)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        logic [5:0] m;
        logic [4:0] a;
        int         delay;
        logic       exp_fail;
        logic [5:0] exp_multi;
        logic [4:0] exp_avg;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic       is_fail;
        logic [5:0] m;
        logic [4:0] a;
        int         lat;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic go_idle();
        @(negedge ref_clk);
        stop = 1'b1;
        lock_flag = 1'b0;
        @(negedge ref_clk);
        stop = 1'b0;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_fail", 32'(fail), 32'd0);
        check("idle_fll_rst", 32'(fll_rst), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        exp_t got;
        int   k;
        int   rst_cnt;
        int   cyc;
        logic stable;
        logic done;
        go_idle();
        start     = 1'b1;
        multi_cfg = v.m;
        avg_cfg   = v.a;
        e.is_fail = v.exp_fail;
        e.m       = v.exp_multi;
        e.a       = v.exp_avg;
        e.lat     = v.exp_lat;
        sb.push_back(e);
        @(negedge ref_clk);
        start   = 1'b0;
        k       = -1;
        rst_cnt = 0;
        cyc     = 0;
        stable  = 1'b1;
        done    = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (locked || fail) begin
                done = 1'b1;
                cyc  = c;
                break;
            end
            if (!fll_rst) begin
                k++;
                if (k == v.delay) lock_flag = 1'b1;
            end else begin
                rst_cnt++;
            end
            if (busy && (multi != v.exp_multi || avg_window != v.exp_avg)) stable = 1'b0;
            @(negedge ref_clk);
        end
        check("vec_outcome_seen", 32'(done), 32'd1);
        if (done) begin
            got = sb.pop_front();
            check("vec_fail_flag", 32'(fail), 32'(got.is_fail));
            check("vec_multi", 32'(multi), 32'(got.m));
            check("vec_avg", 32'(avg_window), 32'(got.a));
            if (got.is_fail) begin
                check("vec_fail_latency", 32'(cyc), 32'd0);
                check("vec_fail_busy", 32'(busy), 32'd0);
                check("vec_fail_fll_rst", 32'(fll_rst), 32'd1);
            end else begin
                check("vec_lock_latency", 32'(k + 1), 32'(got.lat));
                check("vec_rst_cycles", 32'(rst_cnt), 32'd4);
                check("vec_retry", 32'(retry_cnt), 32'd0);
                check("vec_cfg_stable", 32'(stable), 32'd1);
            end
        end
    endtask

    task automatic wait_locked(input string name);
        int n;
        n = 0;
        while (!locked && n < 200) begin
            @(negedge ref_clk);
            n++;
        end
        check(name, 32'(locked), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        int   acq;
        int   falls;
        logic prev_rst;

        vecs[0] = '{6'd1,  5'd7,  0,  1'b1, 6'd0,  5'd0,  0};
        vecs[1] = '{6'd10, 5'd10, 50, 1'b0, 6'd10, 5'd10, 53};
        vecs[2] = '{6'd2,  5'd31, 0,  1'b0, 6'd2,  5'd31, 3};
        vecs[3] = '{6'd63, 5'd0,  5,  1'b0, 6'd63, 5'd0,  8};
        vecs[4] = '{6'd0,  5'd3,  0,  1'b1, 6'd63, 5'd0,  0};

        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        multi_cfg = '0;
        avg_cfg = '0;
        lock_flag = 1'b0;
        clk_con = 5'd16;
        repeat (3) @(negedge ref_clk);
        check("rst_fll_rst", 32'(fll_rst), 32'd1);
        check("rst_multi", 32'(multi), 32'd0);
        check("rst_avg", 32'(avg_window), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);
        check("rst_lol", 32'(lol_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Loss-of-lock filter: 2-cycle dip tolerated, 3-cycle dip faults.
        run_vec('{6'd12, 5'd4, 2, 1'b0, 6'd12, 5'd4, 5});
        lock_flag = 1'b0;
        repeat (2) @(negedge ref_clk);
        lock_flag = 1'b1;
        repeat (4) @(negedge ref_clk);
        check("lol2_locked", 32'(locked), 32'd1);
        check("lol2_cnt", 32'(lol_cnt), 32'd0);
        lock_flag = 1'b0;
        repeat (3) @(negedge ref_clk);
        lock_flag = 1'b1;
        cnt = 0;
        while (!fll_rst && cnt < 10) begin
            @(negedge ref_clk);
            cnt++;
        end
        cnt = 0;
        while (fll_rst && cnt < 20) begin
            cnt++;
            @(negedge ref_clk);
        end
        check("lol3_rst_pulse", 32'(cnt), 32'd4);
        check("lol3_cnt", 32'(lol_cnt), 32'd1);
        check("lol3_retry", 32'(retry_cnt), 32'd1);
        wait_locked("lol3_relock");

        // start while LOCKED is ignored.
        start = 1'b1;
        multi_cfg = 6'd5;
        avg_cfg = 5'd1;
        @(negedge ref_clk);
        start = 1'b0;
        repeat (2) @(negedge ref_clk);
        check("start_in_locked", 32'(locked), 32'd1);
        check("start_in_locked_multi", 32'(multi), 32'd12);
        check("start_in_locked_avg", 32'(avg_window), 32'd4);

        clk_con = 5'd31;
        repeat (8) @(negedge ref_clk);
        clk_con = 5'd16;
        repeat (3) @(negedge ref_clk);
`ifdef FLL_RAIL_DET_EN
        check("rail_lol_cnt", 32'(lol_cnt), 32'd2);
        check("rail_fll_rst", 32'(fll_rst), 32'd1);
        check("rail_retry", 32'(retry_cnt), 32'd2);
`else
        check("rail_ignored_lol", 32'(lol_cnt), 32'd1);
        check("rail_ignored_locked", 32'(locked), 32'd1);
`endif
        wait_locked("rail_relock");

        // stop coincides with the synced lock rise in ACQUIRE.
        go_idle();
        start = 1'b1;
        multi_cfg = 6'd8;
        avg_cfg = 5'd2;
        @(negedge ref_clk);
        start = 1'b0;
        cnt = 0;
        while (fll_rst && cnt < 20) begin
            @(negedge ref_clk);
            cnt++;
        end
        lock_flag = 1'b1;
        repeat (2) @(negedge ref_clk);
        stop = 1'b1;
        @(negedge ref_clk);
        stop = 1'b0;
        check("stop_lock_locked", 32'(locked), 32'd0);
        check("stop_lock_busy", 32'(busy), 32'd0);
        check("stop_lock_fll_rst", 32'(fll_rst), 32'd1);
        repeat (3) @(negedge ref_clk);
        check("stop_lock_stays_idle", 32'(locked), 32'd0);

        // No lock ever: four full timeouts, then FAIL.
        go_idle();
        start = 1'b1;
        multi_cfg = 6'd20;
        avg_cfg = 5'd5;
        @(negedge ref_clk);
        start = 1'b0;
        acq = 0;
        falls = 0;
        prev_rst = 1'b1;
        cnt = 0;
        while (!fail && cnt < 6000) begin
            if (!fll_rst) acq++;
            if (prev_rst && !fll_rst) falls++;
            prev_rst = fll_rst;
            @(negedge ref_clk);
            cnt++;
        end
        check("timeout_fail", 32'(fail), 32'd1);
        check("timeout_acq_cycles", 32'(acq), 32'd4092);
        check("timeout_attempts", 32'(falls), 32'd4);
        check("timeout_retry", 32'(retry_cnt), 32'd3);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_fll_rst", 32'(fll_rst), 32'd1);
        check("timeout_locked", 32'(locked), 32'd0);

        stop = 1'b1;
        @(negedge ref_clk);
        stop = 1'b0;
        check("fail_stop_fail", 32'(fail), 32'd0);
        check("fail_stop_busy", 32'(busy), 32'd0);
        check("fail_stop_multi", 32'(multi), 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
